// File: rtl/up_down_count_monitor.sv
// ---------------------------------------------------------------------------
// up_down_count_monitor
//
// Receive-side health checker for an N-bit up/down counter. Every clock it
// samples the counter value together with the direction control that was
// driven to the counter. It acquires lock after LOCK_LEN consecutive correct
// +/-1 steps. Once locked it does three things:
//   - flags each sample that is not the predicted step,
//   - reports roll-over in either direction,
//   - keeps a saturating tally of flagged samples.
// After MISS_LIMIT consecutive bad samples it drops back to acquisition.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous reset, active-low
//   en       in   1 = cnt_in/ud carry a valid sample this cycle
//   ud       in   counter direction control (0 = up, 1 = down)
//   cnt_in   in   [N-1:0] counter output value
//   locked   out  1 while in LOCK
//   err      out  one-cycle pulse, sample mismatched while locked
//   wrap_up  out  one-cycle pulse, locked correct step 2^N-1 -> 0 counting up
//   wrap_dn  out  one-cycle pulse, locked correct step 0 -> 2^N-1 counting down
//   expected out  [N-1:0] value predicted for the next sample
//   err_cnt  out  [7:0] number of err pulses since reset, saturates at 255
// ---------------------------------------------------------------------------
module up_down_count_monitor #(
  parameter int N          = 4,
  parameter int LOCK_LEN   = 3,
  parameter int MISS_LIMIT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         ud,
  input  logic [N-1:0] cnt_in,
  output logic         locked,
  output logic         err,
  output logic         wrap_up,
  output logic         wrap_dn,
  output logic [N-1:0] expected,
  output logic [7:0]   err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  // Saturating increment for the error tally.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end
    return v + 8'd1;
  endfunction

  // Next value of an N-bit up/down counter from 'v' in direction 'dn'.
  function automatic logic [N-1:0] step_val(input logic [N-1:0] v,
                                            input logic dn);
    if (dn) begin
      return v - N'(1);
    end
    return v + N'(1);
  endfunction

  // Registered history and outputs.
  state_t         state_q,     state_d;
  logic [N-1:0]   prev_q,      prev_d;
  logic           prev_ud_q,   prev_ud_d;
  logic           have_prev_q, have_prev_d;
  logic [3:0]     run_q,       run_d;
  logic           locked_q,    locked_d;
  logic           err_q,       err_d;
  logic           wrap_up_q,   wrap_up_d;
  logic           wrap_dn_q,   wrap_dn_d;
  logic [N-1:0]   expected_q,  expected_d;
  logic [7:0]     err_cnt_q,   err_cnt_d;

  // Step judgement.
  logic [N-1:0]   pred;
  logic           step_ok;
  logic [3:0]     run_inc;
  logic           at_max;
  logic           at_min;

  // The step is judged against the direction captured with the previous
  // sample, so a reversal at any value (including 0 or 2^N-1) is legal.
  assign pred    = step_val(prev_q, prev_ud_q);
  assign step_ok = have_prev_q && (cnt_in == pred);
  assign run_inc = run_q + 4'd1;
  assign at_max  = (prev_q == {N{1'b1}});
  assign at_min  = (prev_q == {N{1'b0}});

  // -------------------------------------------------------------------------
  // State and history registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      prev_q      <= '0;
      prev_ud_q   <= 1'b0;
      have_prev_q <= 1'b0;
      run_q       <= 4'd0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      wrap_up_q   <= 1'b0;
      wrap_dn_q   <= 1'b0;
      expected_q  <= '0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      prev_ud_q   <= prev_ud_d;
      have_prev_q <= have_prev_d;
      run_q       <= run_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      wrap_up_q   <= wrap_up_d;
      wrap_dn_q   <= wrap_dn_d;
      expected_q  <= expected_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    prev_ud_d   = prev_ud_q;
    have_prev_d = have_prev_q;
    run_d       = run_q;
    err_d       = 1'b0;
    wrap_up_d   = 1'b0;
    wrap_dn_d   = 1'b0;
    expected_d  = expected_q;
    err_cnt_d   = err_cnt_q;

    // Every valid sample refreshes the history and the prediction,
    // whatever the state.
    if (en) begin
      prev_d      = cnt_in;
      prev_ud_d   = ud;
      have_prev_d = 1'b1;
      expected_d  = step_val(cnt_in, ud);
    end

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          run_d   = 4'd0;
          state_d = ST_ACQ;
        end
      end

      ST_ACQ: begin
        if (!en) begin
          // A gap breaks the sequence; the next sample starts afresh.
          state_d     = ST_IDLE;
          run_d       = 4'd0;
          have_prev_d = 1'b0;
        end else if (step_ok) begin
          if (run_inc == 4'(LOCK_LEN)) begin
            state_d = ST_LOCK;
            run_d   = 4'd0;
          end else begin
            run_d = run_inc;
          end
        end else begin
          // Acquisition misses are silent; just restart the streak.
          run_d = 4'd0;
        end
      end

      ST_LOCK: begin
        if (!en) begin
          state_d     = ST_IDLE;
          run_d       = 4'd0;
          have_prev_d = 1'b0;
        end else if (step_ok) begin
          run_d     = 4'd0;
          wrap_up_d = !prev_ud_q && at_max;
          wrap_dn_d =  prev_ud_q && at_min;
        end else begin
          err_d     = 1'b1;
          err_cnt_d = sat_inc8(err_cnt_q);
          // While locked, run counts consecutive bad samples.
          if (run_inc == 4'(MISS_LIMIT)) begin
            state_d = ST_ACQ;
            run_d   = 4'd0;
          end else begin
            run_d = run_inc;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        run_d   = 4'd0;
      end
    endcase

    // The lock flag is registered alongside the state it reflects.
    locked_d = (state_d == ST_LOCK);
  end

  assign locked   = locked_q;
  assign err      = err_q;
  assign wrap_up  = wrap_up_q;
  assign wrap_dn  = wrap_dn_q;
  assign expected = expected_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_up_down_count_monitor.sv
module tb_up_down_count_monitor;

  localparam int N          = 4;
  localparam int LOCK_LEN   = 3;
  localparam int MISS_LIMIT = 2;
  localparam int N2         = 1 << N;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         ud;
  logic [N-1:0] cnt_in;
  logic         locked;
  logic         err;
  logic         wrap_up;
  logic         wrap_dn;
  logic [N-1:0] expected;
  logic [7:0]   err_cnt;

  int checks = 0;
  int errors = 0;

  up_down_count_monitor #(
    .N(N), .LOCK_LEN(LOCK_LEN), .MISS_LIMIT(MISS_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ud(ud), .cnt_in(cnt_in),
    .locked(locked), .err(err), .wrap_up(wrap_up), .wrap_dn(wrap_dn),
    .expected(expected), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed=%0d required=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: tracks the last sample, its direction, whether the
  // monitor is engaged (acquiring or locked), and separate good/bad streaks.
  bit m_have, m_dir, m_active, m_lock;
  int m_last, m_good, m_bad, m_errs, m_exp;
  bit e_err, e_wu, e_wd;

  function automatic int nxt(input int v, input bit dn);
    return (v + (dn ? N2 - 1 : 1)) % N2;
  endfunction

  task automatic m_reset();
    m_have = 0; m_dir = 0; m_active = 0; m_lock = 0;
    m_last = 0; m_good = 0; m_bad = 0; m_errs = 0; m_exp = 0;
    e_err = 0; e_wu = 0; e_wd = 0;
  endtask

  task automatic m_sample(input bit e, input bit u, input int c);
    bit ok;
    e_err = 0; e_wu = 0; e_wd = 0;
    if (!e) begin
      if (m_active) begin
        m_active = 0; m_lock = 0; m_have = 0; m_good = 0; m_bad = 0;
      end
      return;
    end
    ok = m_have && (c == nxt(m_last, m_dir));
    if (!m_active) begin
      m_active = 1; m_good = 0;
    end else if (!m_lock) begin
      if (ok) begin
        m_good++;
        if (m_good == LOCK_LEN) begin m_lock = 1; m_bad = 0; end
      end else m_good = 0;
    end else begin
      if (ok) begin
        m_bad = 0;
        e_wu = !m_dir && (m_last == N2 - 1);
        e_wd =  m_dir && (m_last == 0);
      end else begin
        e_err = 1;
        if (m_errs < 255) m_errs++;
        m_bad++;
        if (m_bad == MISS_LIMIT) begin m_lock = 0; m_good = 0; end
      end
    end
    m_last = c; m_dir = u; m_have = 1; m_exp = nxt(c, u);
  endtask

  // One sample: drive on the falling edge, let the DUT take it on the
  // rising edge, then compare every output against the model.
  task automatic step(input bit e, input bit u, input int c);
    @(negedge clk);
    en = e; ud = u; cnt_in = N'(c);
    @(posedge clk);
    m_sample(e, u, c);
    #1;
    chk("locked",   locked,   m_lock);
    chk("err",      err,      e_err);
    chk("wrap_up",  wrap_up,  e_wu);
    chk("wrap_dn",  wrap_dn,  e_wd);
    chk("expected", expected, m_exp);
    chk("err_cnt",  err_cnt,  m_errs);
  endtask

  task automatic run_seq(input int start, input int len, input bit u);
    for (int i = 0; i < len; i++)
      step(1'b1, u, ((start + (u ? -i : i)) % N2 + N2) % N2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int c;
    bit u, e;
    rst = 1'b0; en = 1'b0; ud = 1'b0; cnt_in = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked",   locked,   0);
    chk("rst_err",      err,      0);
    chk("rst_expected", expected, 0);
    chk("rst_err_cnt",  err_cnt,  0);
    @(negedge clk);
    rst = 1'b1;

    // Up count to lock.
    run_seq(0, 5, 1'b0);
    chk("up_locked",   locked,   1);
    chk("up_expected", expected, 5);

    // Continue up through the roll-over, then turn around at 0.
    run_seq(5, 11, 1'b0);
    step(1'b1, 1'b0, 0);
    chk("wrap_up_pulse", wrap_up, 1);
    step(1'b1, 1'b1, 1);
    step(1'b1, 1'b1, 0);
    step(1'b1, 1'b1, 15);
    chk("wrap_dn_pulse", wrap_dn, 1);

    // One-cycle gap while locked.
    step(1'b0, 1'b1, 0);
    chk("gap_locked",  locked,  0);
    chk("gap_err_cnt", err_cnt, 0);

    // Counter's real 32-cycle pattern: 16 up, then down.
    c = 0;
    for (int k = 0; k < 32; k++) begin
      u = (k >= 16);
      step(1'b1, u, c);
      c = nxt(c, u);
    end
    chk("rev_locked",  locked,  1);
    chk("rev_err_cnt", err_cnt, 0);

    // Glitch, unlock and re-lock.
    step(1'b0, 1'b0, 0);
    run_seq(1, 6, 1'b0);
    step(1'b1, 1'b0, 9);
    step(1'b1, 1'b0, 7);
    chk("glitch_err_cnt", err_cnt, 2);
    chk("glitch_unlock",  locked,  0);
    run_seq(8, 3, 1'b0);
    chk("relock", locked, 1);

    // Random counter traffic with gaps, reversals and corrupted samples.
    c = $urandom_range(0, N2 - 1);
    u = 1'b0;
    for (int k = 0; k < 400; k++) begin
      int s;
      e = ($urandom_range(0, 11) != 0);
      if ($urandom_range(0, 5) == 0) u = ~u;
      s = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, N2 - 1)) : c;
      step(e, u, s);
      if (e) c = nxt(s, u);
    end

    // Saturation: lock, two bad samples, gap; repeated.
    for (int k = 0; k < 150; k++) begin
      step(1'b0, 1'b0, 0);
      run_seq(0, 4, 1'b0);
      step(1'b1, 1'b0, 8);
      step(1'b1, 1'b0, 13);
    end
    chk("sat_err_cnt", err_cnt, 255);

    // Async reset while locked with err_cnt = 3.
    do_reset();
    run_seq(0, 4, 1'b0);
    step(1'b1, 1'b0, 9);
    step(1'b1, 1'b0, 10);
    step(1'b1, 1'b0, 15);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 5);
    step(1'b1, 1'b0, 6);
    chk("pre_ar_locked",  locked,  1);
    chk("pre_ar_err_cnt", err_cnt, 3);
    @(negedge clk);
    #2 rst = 1'b0;
    m_reset();
    #1;
    chk("ar_locked",   locked,   0);
    chk("ar_err",      err,      0);
    chk("ar_wrap_up",  wrap_up,  0);
    chk("ar_wrap_dn",  wrap_dn,  0);
    chk("ar_expected", expected, 0);
    chk("ar_err_cnt",  err_cnt,  0);
    @(negedge clk);
    rst = 1'b1;
    run_seq(3, 5, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/up_down_count_monitor.md
# up_down_count_monitor

- Receive-side checker for the N-bit up/down counter.
- Samples the counter's count output and its `ud` control every clock and locks onto the sequence.
- Once locked, flags every sample that is not the correct ±1 step, reports roll-over events and keeps a saturating error tally.
- Sits beside the counter in the integration bench and in-system as a health monitor.

## Interface
- N, 4, count width; must match the monitored counter.
- LOCK_LEN, 3, consecutive correct steps needed to enter LOCK (1..15).
- MISS_LIMIT, 2, consecutive bad steps in LOCK that force loss of lock (1..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- en  input  1  sample valid; 1 = `cnt_in`/`ud` are valid this cycle.
- ud  input  1  counter direction control as driven to the counter (0 = up, 1 = down).
- cnt_in  input  N  counter output value.
- locked  output  1  1 while in LOCK.
- err  output  1  one-cycle pulse: a sample mismatched while in LOCK.
- wrap_up  output  1  one-cycle pulse: correct step from 2^N−1 to 0 with `ud` = 0, in LOCK.
- wrap_dn  output  1  one-cycle pulse: correct step from 0 to 2^N−1 with `ud` = 1, in LOCK.
- expected  output  N  value predicted for the next sample.
- err_cnt  output  8  number of `err` pulses since reset, saturating at 255.

## Operation
- Registered history:
  - `prev` (N bits): last valid sample.
  - `prev_ud`: `ud` captured with `prev`.
  - `have_prev`: 1 = `prev` holds a usable sample.
  - `run` (4 bits): correct-step count while acquiring, bad-step count while locked.
- Prediction: `expected` = `prev` + 1 when `prev_ud` = 0, else `prev` − 1, modulo 2^N.
- A valid sample is correct when `cnt_in` == `expected` and `have_prev` = 1.
- On every valid sample: `prev` ← `cnt_in`, `prev_ud` ← `ud`, `have_prev` ← 1.
- States:
  - IDLE:
    - First valid sample loads history, `run` ← 0, go to ACQ.
    - While `en` = 0, stay in IDLE.
  - ACQ:
    - Correct sample: `run` ← `run` + 1. When `run` reaches LOCK_LEN, go to LOCK with `run` ← 0.
    - Incorrect sample: `run` ← 0, stay in ACQ. No `err` is raised.
  - LOCK:
    - Correct sample: `run` ← 0. Raise `wrap_up`/`wrap_dn` when the roll-over condition holds.
    - Incorrect sample: pulse `err`, increment `err_cnt` unless it is already 255, `run` ← `run` + 1.
    - When `run` reaches MISS_LIMIT, go to ACQ with `run` ← 0.
- `en` = 0 in ACQ or LOCK is a gap:
  - Go to IDLE, `run` ← 0, `have_prev` ← 0.
  - No `err` is raised.
  - `err_cnt` is kept.
- Direction changes are legal. The step is judged by the `ud` captured with the previous sample, so reversal at any value, including 0 or 2^N−1, is not an error.
- Arithmetic is unsigned N-bit with natural wrap. `err_cnt` is unsigned 8-bit and saturates.

## Timing
- Reset (`rst` low, async) forces:
  - state IDLE
  - `locked` = 0, `err` = 0, `wrap_up` = 0, `wrap_dn` = 0
  - `expected` = 0, `err_cnt` = 0
  - `prev` = 0, `prev_ud` = 0, `have_prev` = 0, `run` = 0
- Reset release is taken on the next clk edge. No sample is taken while `rst` is low.
- All outputs are registered. `err`, `wrap_up`, `wrap_dn` and `locked` reflect the sample captured at edge k, visible after edge k.
- `expected` updates on the same edge as `prev`.
- Lock latency from the first valid sample after IDLE: LOCK_LEN + 1 sample edges (default 4).
- Unlock happens on the edge of the MISS_LIMIT-th consecutive bad sample. `err` pulses on that edge as well.
- Pulses last exactly one cycle. Back-to-back bad samples give back-to-back `err` pulses.
- `err` and a wrap pulse are mutually exclusive.
- Reset asserted mid-LOCK clears `err_cnt` and all state immediately, without waiting for a clock.

## Test plan
- Up count:
  - Stimulus: reset, then `en` = 1, `ud` = 0, `cnt_in` = 0,1,2,3,4.
  - Response: `locked` rises after the 4th sample edge, `err` never pulses, `expected` = 5 after the sample 4.
- Wrap both ways (locked):
  - Stimulus: up count 14, 15, 0.
  - Response: `wrap_up` pulses once, on the sample 0.
  - Stimulus: then `ud` = 1 and samples 1, 0, 15.
  - Response: `wrap_dn` pulses once, on the sample 15. No `err` anywhere.
- Direction reversal: drive the counter's actual 32-cycle pattern (16 up, then down) through the sequence. Response: no `err`, `locked` stays 1 through the reversal.
- Glitch and unlock (locked, up):
  - Stimulus: samples 5,6,9,7.
  - Response: `err` pulses on 9 and on 7, `err_cnt` = 2, `locked` falls on the 7 edge.
  - Stimulus: samples 8,9,10.
  - Response: re-lock on the 10 edge.
- Gap and saturation:
  - Gap: drop `en` for 1 cycle while locked. Response: state goes to IDLE, `locked` = 0, `err_cnt` unchanged.
  - Saturation: force 300 mismatches, with a gap every 2 samples to keep re-acquiring. Response: `err_cnt` holds at 255.
- Async reset: assert `rst` low between clock edges while locked with `err_cnt` = 3. Response: all outputs are 0 before the next edge.
